id_ex_stage: RTL and testbench

//   ID->EX pipeline stage directly upstream of the ALU. Decodes a 32-bit MIPS instruction,

---
 rtl/id_ex_stage.sv | 202 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with MIPS decode feeding the ALU operands,
// ALU opCode and the memory/writeback controls. Supports stall and flush.
module id_ex_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [31:0]  instr,
    input  logic [N-1:0] rs_data,
    input  logic [N-1:0] rt_data,
    output logic         ex_valid,
    output logic [N-1:0] ex_busA,
    output logic [N-1:0] ex_busB,
    output logic [3:0]   ex_opCode,
    output logic [4:0]   ex_dest,
    output logic         ex_reg_write,
    output logic         ex_mem_read,
    output logic         ex_mem_write,
    output logic [N-1:0] ex_store_data,
    output logic         ex_illegal
);

    // ALU operation encodings
    localparam logic [3:0] ALU_SLL = 4'd0;
    localparam logic [3:0] ALU_SRL = 4'd1;
    localparam logic [3:0] ALU_SRA = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_XOR = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;

    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [N-1:0] imm_sx;
    logic [N-1:0] imm_zx;
    logic [N-1:0] shamt_zx;
    logic [N-1:0] lui_shift;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign imm_zx    = {{(N-16){1'b0}}, instr[15:0]};
    assign shamt_zx  = {{(N-5){1'b0}}, instr[10:6]};
    assign lui_shift = N'(16);

    // Sign extension: low half is imm16, every upper bit copies imm16[15]
    assign imm_sx[15:0] = instr[15:0];
    genvar gi;
    generate
        for (gi = 16; gi < N; gi++) begin : g_sext
            assign imm_sx[gi] = instr[15];
        end
    endgenerate

    logic         supported;
    logic         is_store;
    logic         is_load;
    logic [N-1:0] bus_a_dec;
    logic [N-1:0] bus_b_dec;
    logic [3:0]   op_dec;
    logic [4:0]   dest_dec;

    // Instruction decode into ALU operands and controls
    always_comb begin
        supported = 1'b1;
        is_store  = 1'b0;
        is_load   = 1'b0;
        bus_a_dec = rs_data;
        bus_b_dec = rt_data;
        op_dec    = ALU_SLL;
        dest_dec  = instr[15:11];
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00: begin bus_a_dec = shamt_zx; op_dec = ALU_SLL; end
                    6'h02: begin bus_a_dec = shamt_zx; op_dec = ALU_SRL; end
                    6'h03: begin bus_a_dec = shamt_zx; op_dec = ALU_SRA; end
                    6'h04: op_dec = ALU_SLL;
                    6'h06: op_dec = ALU_SRL;
                    6'h07: op_dec = ALU_SRA;
                    6'h20, 6'h21: op_dec = ALU_ADD;
                    6'h22, 6'h23: op_dec = ALU_SUB;
                    6'h24: op_dec = ALU_AND;
                    6'h25: op_dec = ALU_OR;
                    6'h26: op_dec = ALU_XOR;
                    6'h27: op_dec = ALU_NOR;
                    6'h2A: op_dec = ALU_SLT;
                    default: supported = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin bus_b_dec = imm_sx; op_dec = ALU_ADD; dest_dec = instr[20:16]; end
            6'h0A: begin bus_b_dec = imm_sx; op_dec = ALU_SLT; dest_dec = instr[20:16]; end
            6'h0C: begin bus_b_dec = imm_zx; op_dec = ALU_AND; dest_dec = instr[20:16]; end
            6'h0D: begin bus_b_dec = imm_zx; op_dec = ALU_OR;  dest_dec = instr[20:16]; end
            6'h0E: begin bus_b_dec = imm_zx; op_dec = ALU_XOR; dest_dec = instr[20:16]; end
            // LUI: ALU shifts the zero-extended immediate left by 16
            6'h0F: begin
                bus_a_dec = lui_shift;
                bus_b_dec = imm_zx;
                op_dec    = ALU_SLL;
                dest_dec  = instr[20:16];
            end
            6'h23: begin
                bus_b_dec = imm_sx;
                op_dec    = ALU_ADD;
                dest_dec  = instr[20:16];
                is_load   = 1'b1;
            end
            6'h2B: begin
                bus_b_dec = imm_sx;
                op_dec    = ALU_ADD;
                dest_dec  = instr[20:16];
                is_store  = 1'b1;
            end
            default: supported = 1'b0;
        endcase
    end

    logic         valid_next;
    logic [N-1:0] bus_a_next;
    logic [N-1:0] bus_b_next;
    logic [3:0]   op_next;
    logic [4:0]   dest_next;
    logic         reg_write_next;
    logic         mem_read_next;
    logic         mem_write_next;
    logic [N-1:0] store_data_next;
    logic         illegal_next;

    // Select between a decoded instruction and a bubble for the next load edge
    always_comb begin
        valid_next      = 1'b0;
        bus_a_next      = '0;
        bus_b_next      = '0;
        op_next         = 4'd0;
        dest_next       = 5'd0;
        reg_write_next  = 1'b0;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        store_data_next = '0;
        illegal_next    = 1'b0;
        if (in_valid) begin
            if (supported) begin
                valid_next      = 1'b1;
                bus_a_next      = bus_a_dec;
                bus_b_next      = bus_b_dec;
                op_next         = op_dec;
                dest_next       = dest_dec;
                reg_write_next  = !is_store && (dest_dec != 5'd0);
                mem_read_next   = is_load;
                mem_write_next  = is_store;
                store_data_next = rt_data;
            end else begin
                illegal_next    = 1'b1;
            end
        end
    end

    // Pipeline register: reset > flush > stall > load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_busA       <= '0;
            ex_busB       <= '0;
            ex_opCode     <= 4'd0;
            ex_dest       <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_store_data <= '0;
            ex_illegal    <= 1'b0;
        end else if (flush) begin
            ex_valid      <= 1'b0;
            ex_busA       <= '0;
            ex_busB       <= '0;
            ex_opCode     <= 4'd0;
            ex_dest       <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_store_data <= '0;
            ex_illegal    <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= valid_next;
            ex_busA       <= bus_a_next;
            ex_busB       <= bus_b_next;
            ex_opCode     <= op_next;
            ex_dest       <= dest_next;
            ex_reg_write  <= reg_write_next;
            ex_mem_read   <= mem_read_next;
            ex_mem_write  <= mem_write_next;
            ex_store_data <= store_data_next;
            ex_illegal    <= illegal_next;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with hand-computed expected values.
module tb_id_ex_stage;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  instr = 32'h0;
    logic [N-1:0] rs_data = '0;
    logic [N-1:0] rt_data = '0;
    logic         ex_valid;
    logic [N-1:0] ex_busA;
    logic [N-1:0] ex_busB;
    logic [3:0]   ex_opCode;
    logic [4:0]   ex_dest;
    logic         ex_reg_write;
    logic         ex_mem_read;
    logic         ex_mem_write;
    logic [N-1:0] ex_store_data;
    logic         ex_illegal;

    int vectors = 0;
    int miscompares = 0;

    id_ex_stage #(.N(N)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .ex_valid(ex_valid), .ex_busA(ex_busA), .ex_busB(ex_busB),
        .ex_opCode(ex_opCode), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against its expected value
    task automatic check_all(input string tag, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] op, input logic [4:0] d,
                             input logic rw, input logic mr, input logic mw,
                             input logic [31:0] sd, input logic ill);
        check({tag, ".valid"}, 32'(ex_valid), 32'(v));
        check({tag, ".busA"}, ex_busA, a);
        check({tag, ".busB"}, ex_busB, b);
        check({tag, ".opCode"}, 32'(ex_opCode), 32'(op));
        check({tag, ".dest"}, 32'(ex_dest), 32'(d));
        check({tag, ".reg_write"}, 32'(ex_reg_write), 32'(rw));
        check({tag, ".mem_read"}, 32'(ex_mem_read), 32'(mr));
        check({tag, ".mem_write"}, 32'(ex_mem_write), 32'(mw));
        check({tag, ".store_data"}, ex_store_data, sd);
        check({tag, ".illegal"}, 32'(ex_illegal), 32'(ill));
        $display("step %s: valid=%0d busA=%h busB=%h op=%0d dest=%0d rw=%0d mr=%0d mw=%0d sd=%h ill=%0d",
                 tag, ex_valid, ex_busA, ex_busB, ex_opCode, ex_dest, ex_reg_write,
                 ex_mem_read, ex_mem_write, ex_store_data, ex_illegal);
    endtask

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        rs_data  = a;
        rt_data  = b;
        step();
    endtask

    initial begin
        // Reset held across edges
        step();
        step();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;

        // ADDI rt=9 rs=8 imm=FFFF
        load(itype(6'h08, 5'd8, 5'd9, 16'hFFFF), 32'd5, 32'h77);
        check_all("addi", 1, 32'd5, 32'hFFFF_FFFF, 3, 9, 1, 0, 0, 32'h77, 0);

        // SLL rd=10 rt=11 shamt=4
        load(rtype(5'd0, 5'd11, 5'd10, 5'd4, 6'h00), 32'h123, 32'h0F);
        check_all("sll", 1, 32'd4, 32'h0F, 0, 10, 1, 0, 0, 32'h0F, 0);

        // SRAV rd=3
        load(rtype(5'd7, 5'd8, 5'd3, 5'd0, 6'h07), 32'd5, 32'h8000_0000);
        check_all("srav", 1, 32'd5, 32'h8000_0000, 2, 3, 1, 0, 0, 32'h8000_0000, 0);

        // LUI rt=2 imm=1234
        load(itype(6'h0F, 5'd0, 5'd2, 16'h1234), 32'hDEAD, 32'h1);
        check_all("lui", 1, 32'd16, 32'h1234, 0, 2, 1, 0, 0, 32'h1, 0);

        // ORI imm=8000 is zero-extended
        load(itype(6'h0D, 5'd3, 5'd4, 16'h8000), 32'hAA, 32'h2);
        check_all("ori", 1, 32'hAA, 32'h0000_8000, 6, 4, 1, 0, 0, 32'h2, 0);

        // SLTI imm=8000 is sign-extended
        load(itype(6'h0A, 5'd3, 5'd7, 16'h8000), 32'h11, 32'h3);
        check_all("slti", 1, 32'h11, 32'hFFFF_8000, 9, 7, 1, 0, 0, 32'h3, 0);

        // NOR rd=31
        load(rtype(5'd1, 5'd2, 5'd31, 5'd0, 6'h27), 32'hF0F0, 32'h0F0F);
        check_all("nor", 1, 32'hF0F0, 32'h0F0F, 8, 31, 1, 0, 0, 32'h0F0F, 0);

        // LW rt=5 imm=4
        load(itype(6'h23, 5'd1, 5'd5, 16'h0004), 32'h200, 32'h9);
        check_all("lw", 1, 32'h200, 32'h4, 3, 5, 1, 1, 0, 32'h9, 0);

        // SW rt=6 rs=1 imm=-4
        load(itype(6'h2B, 5'd1, 5'd6, 16'hFFFC), 32'h100, 32'hCAFE);
        check_all("sw", 1, 32'h100, 32'hFFFF_FFFC, 3, 6, 0, 0, 1, 32'hCAFE, 0);

        // Stall for 3 cycles while the input changes
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load(rtype(5'd2, 5'd3, 5'd4 + 5'(k), 5'd0, 6'h20), 32'(k + 1), 32'(k + 50));
            check_all("stall_hold", 1, 32'h100, 32'hFFFF_FFFC, 3, 6, 0, 0, 1, 32'hCAFE, 0);
        end

        // Flush wins over stall
        flush = 1'b1;
        step();
        check_all("flush_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0;
        stall = 1'b0;

        // in_valid low loads a bubble
        in_valid = 1'b0;
        instr    = rtype(5'd2, 5'd3, 5'd4, 5'd0, 6'h20);
        step();
        check_all("invalid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // SUB rd=12
        load(rtype(5'd2, 5'd3, 5'd12, 5'd0, 6'h22), 32'd9, 32'd4);
        check_all("sub", 1, 32'd9, 32'd4, 4, 12, 1, 0, 0, 32'd4, 0);

        // Unsupported funct 3F
        load(rtype(5'd2, 5'd3, 5'd12, 5'd0, 6'h3F), 32'd9, 32'd4);
        check_all("bad_funct", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // ADDU to rd=0: illegal cleared, no register write
        load(rtype(5'd2, 5'd3, 5'd0, 5'd0, 6'h21), 32'd7, 32'd8);
        check_all("addu_r0", 1, 32'd7, 32'd8, 3, 0, 0, 0, 0, 32'd8, 0);

        // Unsupported opcode (J), then held by stall, then cleared by next load
        load(itype(6'h02, 5'd0, 5'd0, 16'h0010), 32'd1, 32'd2);
        check_all("bad_op", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        stall = 1'b1;
        load(itype(6'h0C, 5'd1, 5'd8, 16'h00FF), 32'h1234, 32'd3);
        check_all("bad_op_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        stall = 1'b0;
        load(itype(6'h0C, 5'd1, 5'd8, 16'h00FF), 32'h1234, 32'd3);
        check_all("andi", 1, 32'h1234, 32'h00FF, 5, 8, 1, 0, 0, 32'd3, 0);

        // Asynchronous reset between edges, during a stall
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        stall = 1'b0;

        // First capture after reset release
        load(itype(6'h0E, 5'd1, 5'd20, 16'hFFFF), 32'h0F0F, 32'd6);
        check_all("xori_post_reset", 1, 32'h0F0F, 32'h0000_FFFF, 7, 20, 1, 0, 0, 32'd6, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound total runtime
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
